// File: rtl/lsu_pkg.sv
// -----------------------------------------------------------------------------
// lsu_pkg
// Shared types and helpers for the load/store unit.
//   size_e      : request access size encoding (byte/half/word/reserved)
//   state_e     : load/store unit control FSM states
//   word_addr_w : width of the word-address ports for a given memory depth
// -----------------------------------------------------------------------------
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RD   = 2'b01,
        WR   = 2'b10,
        RESP = 2'b11
    } state_e;

    // Word-address port width: word index bits plus one spare MSB that is
    // always driven to zero.
    function automatic int word_addr_w(input int numwords);
        return $clog2(numwords) + 1;
    endfunction

endpackage

// File: rtl/lsu_lane.sv
// -----------------------------------------------------------------------------
// lsu_lane
// Purely combinational byte-lane steering for the load/store unit.
//   Load side : picks the addressed byte/half out of word_i and sign- or
//               zero-extends it (words pass through unchanged).
//   Store side: replaces the addressed byte/half of word_i with the low bits
//               of wdata_i (a word store returns wdata_i as-is).
// Ports:
//   size_i       in   access size
//   lane_i       in   byte address bits [1:0]
//   unsigned_i   in   1 = zero-extend loads, 0 = sign-extend
//   word_i       in   memory word (read data, or captured word for RMW)
//   wdata_i      in   right-aligned store data
//   load_data_o  out  extracted and extended load result
//   store_word_o out  merged word to write back
// The lane arithmetic assumes a 32-bit word (four byte lanes).
// -----------------------------------------------------------------------------
module lsu_lane
    import lsu_pkg::*;
#(
    parameter int DATAWIDTH = 32
) (
    input  size_e                 size_i,
    input  logic [1:0]            lane_i,
    input  logic                  unsigned_i,
    input  logic [DATAWIDTH-1:0]  word_i,
    input  logic [DATAWIDTH-1:0]  wdata_i,
    output logic [DATAWIDTH-1:0]  load_data_o,
    output logic [DATAWIDTH-1:0]  store_word_o
);

    logic [4:0]  lane_lsb;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Bit offset of the addressed byte lane.
    assign lane_lsb = {lane_i, 3'b000};

    always_comb begin
        byte_sel    = word_i[lane_lsb +: 8];
        half_sel    = lane_i[1] ? word_i[31:16] : word_i[15:0];
        load_data_o = word_i;
        case (size_i)
            SZ_BYTE: load_data_o = {{24{~unsigned_i & byte_sel[7]}}, byte_sel};
            SZ_HALF: load_data_o = {{16{~unsigned_i & half_sel[15]}}, half_sel};
            default: load_data_o = word_i;
        endcase
    end

    always_comb begin
        store_word_o = wdata_i;
        case (size_i)
            SZ_BYTE: begin
                store_word_o                  = word_i;
                store_word_o[lane_lsb +: 8]   = wdata_i[7:0];
            end
            SZ_HALF: begin
                store_word_o = word_i;
                if (lane_i[1]) begin
                    store_word_o[31:16] = wdata_i[15:0];
                end else begin
                    store_word_o[15:0]  = wdata_i[15:0];
                end
            end
            default: store_word_o = wdata_i;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
// Request-side initiator for a word-only data memory. Accepts one CPU
// load/store at a time over valid/ready, performs lane extraction for
// sub-word loads and read-modify-write for sub-word stores, and returns a
// single response over valid/ready.
//
// Ports:
//   clk_i, rst_ni                  clock, synchronous active-low reset
//   req_valid_i / req_ready_o      request handshake
//   req_we_i, req_size_i,
//   req_unsigned_i, req_addr_i,
//   req_wdata_i                    request fields (byte address, right-aligned data)
//   rsp_valid_o / rsp_ready_i      response handshake
//   rsp_rdata_o, rsp_err_o         load result (0 for stores/errors), error flag
//   mem_re_o, mem_raddr_o,
//   mem_rdata_i                    combinational read port (word addressed)
//   mem_we_o, mem_waddr_o,
//   mem_wdata_o                    synchronous write port (word addressed)
//
// Build option:
//   LSU_BOUNDS_CHECK_EN  when defined, byte addresses >= 4*NUMWORDS complete
//                        as errors without touching memory; when undefined the
//                        upper address bits are ignored and accesses wrap.
// -----------------------------------------------------------------------------
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int NUMWORDS  = 4096,
    parameter int DATAWIDTH = 32,
    parameter int ADDRWIDTH = 32
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        req_valid_i,
    output logic                        req_ready_o,
    input  logic                        req_we_i,
    input  logic [1:0]                  req_size_i,
    input  logic                        req_unsigned_i,
    input  logic [ADDRWIDTH-1:0]        req_addr_i,
    input  logic [DATAWIDTH-1:0]        req_wdata_i,
    output logic                        rsp_valid_o,
    input  logic                        rsp_ready_i,
    output logic [DATAWIDTH-1:0]        rsp_rdata_o,
    output logic                        rsp_err_o,
    output logic                        mem_re_o,
    output logic [$clog2(NUMWORDS):0]   mem_raddr_o,
    input  logic [DATAWIDTH-1:0]        mem_rdata_i,
    output logic                        mem_we_o,
    output logic [$clog2(NUMWORDS):0]   mem_waddr_o,
    output logic [DATAWIDTH-1:0]        mem_wdata_o
);

    localparam int AW = word_addr_w(NUMWORDS);
    // Only the word index and byte lane of the address are ever needed.
    localparam int LA = AW + 1;

    state_e                 state_q;
    logic                   we_q;
    size_e                  size_q;
    logic                   uns_q;
    logic [LA-1:0]          addr_q;
    logic [DATAWIDTH-1:0]   wdata_q;
    logic [DATAWIDTH-1:0]   rmw_q;
    logic [DATAWIDTH-1:0]   rdata_q;
    logic                   err_q;

    logic                   req_fire;
    logic                   req_bad;
    logic                   req_oob;
    logic [AW-1:0]          word_addr;
    logic [DATAWIDTH-1:0]   lane_word;
    logic [DATAWIDTH-1:0]   load_data;
    logic [DATAWIDTH-1:0]   store_word;
    logic                   unused_addr_hi;

    function automatic logic bad_align(input logic [1:0] size, input logic [1:0] lo);
        logic bad;
        case (size_e'(size))
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = lo[0];
            SZ_WORD: bad = (lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

`ifdef LSU_BOUNDS_CHECK_EN
    localparam logic [ADDRWIDTH:0] ADDR_LIMIT = (ADDRWIDTH+1)'(4 * NUMWORDS);
    assign req_oob = ({1'b0, req_addr_i} >= ADDR_LIMIT);
`else
    assign req_oob = 1'b0;
`endif

    // Upper address bits only matter to the optional bounds check.
    assign unused_addr_hi = ^req_addr_i[ADDRWIDTH-1:LA];

    assign req_fire  = req_valid_i & (state_q == IDLE);
    assign req_bad   = bad_align(req_size_i, req_addr_i[1:0]) | req_oob;
    // Word index zero-extended by one bit to the port width.
    assign word_addr = {1'b0, addr_q[LA-1:2]};

    // During WR the lane merge works on the word captured in RD; otherwise
    // it sees the live read data for load extraction.
    assign lane_word = (state_q == WR) ? rmw_q : mem_rdata_i;

    lsu_lane #(
        .DATAWIDTH (DATAWIDTH)
    ) u_lane (
        .size_i       (size_q),
        .lane_i       (addr_q[1:0]),
        .unsigned_i   (uns_q),
        .word_i       (lane_word),
        .wdata_i      (wdata_q),
        .load_data_o  (load_data),
        .store_word_o (store_word)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            size_q  <= SZ_BYTE;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rmw_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_fire) begin
                        we_q    <= req_we_i;
                        size_q  <= size_e'(req_size_i);
                        uns_q   <= req_unsigned_i;
                        addr_q  <= req_addr_i[LA-1:0];
                        wdata_q <= req_wdata_i;
                        rdata_q <= '0;
                        err_q   <= req_bad;
                        if (req_bad) begin
                            state_q <= RESP;
                        end else if (req_we_i && (size_e'(req_size_i) == SZ_WORD)) begin
                            state_q <= WR;
                        end else begin
                            // Loads and sub-word stores both start with a read.
                            state_q <= RD;
                        end
                    end
                end
                RD: begin
                    if (we_q) begin
                        rmw_q   <= mem_rdata_i;
                        state_q <= WR;
                    end else begin
                        rdata_q <= load_data;
                        state_q <= RESP;
                    end
                end
                WR: begin
                    state_q <= RESP;
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready_o = (state_q == IDLE);
    assign rsp_valid_o = (state_q == RESP);
    assign rsp_rdata_o = rdata_q;
    assign rsp_err_o   = err_q;

    // Enables are gated with reset so an abandoned request never touches memory.
    assign mem_re_o    = rst_ni & (state_q == RD);
    assign mem_we_o    = rst_ni & (state_q == WR);
    assign mem_raddr_o = mem_re_o ? word_addr : '0;
    assign mem_waddr_o = mem_we_o ? word_addr : '0;
    assign mem_wdata_o = mem_we_o ? store_word : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// -----------------------------------------------------------------------------
// tb_load_store_unit
// Self-checking bench: directed scenarios plus randomized traffic compared
// against a byte-level reference memory kept in the bench.
// -----------------------------------------------------------------------------
module tb_load_store_unit;

    localparam int NUMWORDS = 4096;
    localparam int AW       = 13;

    logic          clk = 1'b0;
    logic          rst_ni;
    logic          req_valid, req_ready, req_we, req_unsigned;
    logic [1:0]    req_size;
    logic [31:0]   req_addr, req_wdata;
    logic          rsp_valid, rsp_ready, rsp_err;
    logic [31:0]   rsp_rdata;
    logic          mem_re, mem_we;
    logic [AW-1:0] mem_raddr, mem_waddr;
    logic [31:0]   mem_rdata, mem_wdata;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] mem     [0:NUMWORDS-1];
    logic [31:0] ref_mem [0:NUMWORDS-1];
    logic        init_we = 1'b0;
    logic [11:0] init_addr = '0;
    logic [31:0] init_data = '0;

    always #5 clk = ~clk;

    load_store_unit #(.NUMWORDS(NUMWORDS), .DATAWIDTH(32), .ADDRWIDTH(32)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
        .req_size_i(req_size), .req_unsigned_i(req_unsigned), .req_addr_i(req_addr),
        .req_wdata_i(req_wdata),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
        .rsp_err_o(rsp_err),
        .mem_re_o(mem_re), .mem_raddr_o(mem_raddr), .mem_rdata_i(mem_rdata),
        .mem_we_o(mem_we), .mem_waddr_o(mem_waddr), .mem_wdata_o(mem_wdata)
    );

    // Attached memory: combinational read, synchronous write.
    assign mem_rdata = mem[mem_raddr[11:0]];
    always @(posedge clk) begin
        if (init_we) mem[init_addr] <= init_data;
        else if (mem_we) mem[mem_waddr[11:0]] <= mem_wdata;
    end

    // ---------------- reference model ----------------
    function automatic logic ref_err(input logic [31:0] a, input logic [1:0] sz);
        logic e;
        e = (sz == 2'd3) || (sz == 2'd1 && (a % 2) != 0) || (sz == 2'd2 && (a % 4) != 0);
`ifdef LSU_BOUNDS_CHECK_EN
        if (a >= 32'(4 * NUMWORDS)) e = 1'b1;
`endif
        return e;
    endfunction

    function automatic int ref_widx(input logic [31:0] a);
        return int'((a / 4) % NUMWORDS);
    endfunction

    function automatic logic [31:0] ref_mask(input logic [1:0] sz);
        return (sz == 2'd0) ? 32'h0000_00FF : (sz == 2'd1) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] sz, input logic uns);
        logic [31:0] m, v;
        int sh;
        m  = ref_mask(sz);
        sh = (sz == 2'd2) ? 0 : int'(a % 4) * 8;
        v  = (ref_mem[ref_widx(a)] >> sh) & m;
        if (!uns && sz != 2'd2 && (v & ((m >> 1) + 1)) != 0) v = v | ~m;
        return v;
    endfunction

    function automatic logic [31:0] ref_merge(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd);
        logic [31:0] m;
        int sh;
        m  = ref_mask(sz);
        sh = (sz == 2'd2) ? 0 : int'(a % 4) * 8;
        return (ref_mem[ref_widx(a)] & ~(m << sh)) | ((wd & m) << sh);
    endfunction

    // Drives one request and records what the DUT does, cycle by cycle after accept.
    task automatic xact(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd, input int hold,
                        output logic [31:0] rd, output logic er, output int lat,
                        output int re_cnt, output int we_cnt, output int re_cyc, output int we_cyc,
                        output logic [AW-1:0] ra, output logic [AW-1:0] wa, output logic [31:0] wdat,
                        output int hold_bad, output logic rdy_before);
        rd = '0; er = 1'b0; lat = -1; re_cnt = 0; we_cnt = 0; re_cyc = 0; we_cyc = 0;
        ra = '0; wa = '0; wdat = '0; hold_bad = 0;
        @(negedge clk);
        rdy_before = req_ready;
        req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
        req_addr = a; req_wdata = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom;
        req_size = 2'($urandom); req_we = 1'($urandom);
        for (int k = 1; k <= 12 && lat < 0; k++) begin
            @(negedge clk);
            if (mem_re) begin re_cnt++; re_cyc = k; ra = mem_raddr; end
            if (mem_we) begin we_cnt++; we_cyc = k; wa = mem_waddr; wdat = mem_wdata; end
            if (rsp_valid) begin
                lat = k; rd = rsp_rdata; er = rsp_err;
                if (req_ready !== 1'b0) hold_bad++;
            end
        end
        if (lat > 0) begin
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                if (rsp_valid !== 1'b1 || rsp_rdata !== rd || rsp_err !== er ||
                    req_ready !== 1'b0 || mem_re || mem_we) hold_bad++;
            end
            rsp_ready = 1'b1;
            @(posedge clk);
            #1 rsp_ready = 1'b0;
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset;
        int acc_bad;
        acc_bad = 0;
        rst_ni = 1'b0;
        for (int i = 0; i < NUMWORDS; i++) begin
            @(negedge clk);
            if (mem_re || mem_we) acc_bad++;
            init_we = 1'b1; init_addr = 12'(i); init_data = $urandom;
            ref_mem[i] = init_data;
            if (i > NUMWORDS - 8) req_valid = 1'b1;
        end
        @(negedge clk);
        init_we = 1'b0; req_valid = 1'b0;
        n_cmp++;
        if (acc_bad !== 0) begin n_bad++; $display("FAIL reset_no_access: got %0d accesses want 0", acc_bad); end
        rst_ni = 1'b1;
        @(negedge clk);
        n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", req_ready); end
        n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        n_cmp++; if (rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin n_bad++; $display("FAIL reset_rsp: got err=%b rdata=%h want 0/0", rsp_err, rsp_rdata); end
        n_cmp++; if (mem_re !== 1'b0 || mem_we !== 1'b0 || mem_raddr !== '0 || mem_waddr !== '0) begin
            n_bad++; $display("FAIL reset_mem: got re=%b we=%b ra=%h wa=%h want all 0", mem_re, mem_we, mem_raddr, mem_waddr); end
    endtask

    task automatic test_word;
        logic [31:0] rd, wdat; logic er, rb; int lat, rc, wc, ry, wy, hb; logic [AW-1:0] ra, wa;
        xact(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 0, rd, er, lat, rc, wc, ry, wy, ra, wa, wdat, hb, rb);
        ref_mem[4] = 32'hDEADBEEF;
        n_cmp++; if (wc !== 1 || wy !== 1 || rc !== 0) begin n_bad++; $display("FAIL word_store_we: got we_cnt=%0d at %0d re_cnt=%0d want 1 at 1, 0", wc, wy, rc); end
        n_cmp++; if (wa !== 13'd4 || wdat !== 32'hDEADBEEF) begin n_bad++; $display("FAIL word_store_data: got %h@%0d want deadbeef@4", wdat, wa); end
        n_cmp++; if (lat !== 2 || er !== 1'b0 || rd !== 32'h0) begin n_bad++; $display("FAIL word_store_rsp: got lat=%0d err=%b rd=%h want 2/0/0", lat, er, rd); end
        xact(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0, rd, er, lat, rc, wc, ry, wy, ra, wa, wdat, hb, rb);
        n_cmp++; if (rc !== 1 || ry !== 1 || ra !== 13'd4 || wc !== 0) begin n_bad++; $display("FAIL word_load_re: got re=%0d@%0d ra=%0d we=%0d want 1@1 4 0", rc, ry, ra, wc); end
        n_cmp++; if (lat !== 2 || rd !== 32'hDEADBEEF || er !== 1'b0) begin n_bad++; $display("FAIL word_load_rsp: got lat=%0d rd=%h err=%b want 2 deadbeef 0", lat, rd, er); end
        n_cmp++; if (rb !== 1'b1) begin n_bad++; $display("FAIL back_to_back_ready: got %b want 1", rb); end
    endtask

    task automatic test_byte;
        logic [31:0] rd, wdat; logic er, rb; int lat, rc, wc, ry, wy, hb; logic [AW-1:0] ra, wa;
        xact(1'b1, 2'd0, 1'b0, 32'h11, 32'h123456AB, 0, rd, er, lat, rc, wc, ry, wy, ra, wa, wdat, hb, rb);
        ref_mem[4] = 32'hDEADABEF;
        n_cmp++; if (rc !== 1 || ry !== 1 || ra !== 13'd4) begin n_bad++; $display("FAIL byte_store_re: got re=%0d@%0d ra=%0d want 1@1 4", rc, ry, ra); end
        n_cmp++; if (wc !== 1 || wy !== 2 || wa !== 13'd4 || wdat !== 32'hDEADABEF) begin
            n_bad++; $display("FAIL byte_store_we: got we=%0d@%0d %h@%0d want 1@2 deadabef@4", wc, wy, wdat, wa); end
        n_cmp++; if (lat !== 3 || er !== 1'b0) begin n_bad++; $display("FAIL byte_store_lat: got %0d want 3", lat); end
        xact(1'b0, 2'd0, 1'b0, 32'h11, 32'h0, 0, rd, er, lat, rc, wc, ry, wy, ra, wa, wdat, hb, rb);
        n_cmp++; if (rd !== 32'hFFFFFFAB || lat !== 2) begin n_bad++; $display("FAIL byte_load_signed: got %h lat=%0d want ffffffab lat=2", rd, lat); end
        xact(1'b0, 2'd0, 1'b1, 32'h11, 32'h0, 0, rd, er, lat, rc, wc, ry, wy, ra, wa, wdat, hb, rb);
        n_cmp++; if (rd !== 32'h000000AB) begin n_bad++; $display("FAIL byte_load_unsigned: got %h want 000000ab", rd); end
    endtask

    task automatic test_half;
        logic [31:0] rd, wdat; logic er, rb; int lat, rc, wc, ry, wy, hb; logic [AW-1:0] ra, wa;
        xact(1'b1, 2'd1, 1'b0, 32'h12, 32'hFFFF1234, 0, rd, er, lat, rc, wc, ry, wy, ra, wa, wdat, hb, rb);
        ref_mem[4] = 32'h1234ABEF;
        n_cmp++; if (wdat !== 32'h1234ABEF || wy !== 2 || lat !== 3) begin n_bad++; $display("FAIL half_store: got %h we@%0d lat=%0d want 1234abef we@2 lat=3", wdat, wy, lat); end
        xact(1'b0, 2'd1, 1'b0, 32'h12, 32'h0, 0, rd, er, lat, rc, wc, ry, wy, ra, wa, wdat, hb, rb);
        n_cmp++; if (rd !== 32'h00001234 || er !== 1'b0) begin n_bad++; $display("FAIL half_load: got %h err=%b want 00001234 0", rd, er); end
        xact(1'b0, 2'd1, 1'b0, 32'h13, 32'h0, 0, rd, er, lat, rc, wc, ry, wy, ra, wa, wdat, hb, rb);
        n_cmp++; if (er !== 1'b1 || lat !== 1 || rc !== 0 || wc !== 0 || rd !== 32'h0) begin
            n_bad++; $display("FAIL half_misaligned: got err=%b lat=%0d re=%0d we=%0d rd=%h want 1 1 0 0 0", er, lat, rc, wc, rd); end
    endtask

    task automatic test_backpressure;
        logic [31:0] rd, wdat; logic er, rb; int lat, rc, wc, ry, wy, hb; logic [AW-1:0] ra, wa;
        xact(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 3, rd, er, lat, rc, wc, ry, wy, ra, wa, wdat, hb, rb);
        n_cmp++; if (hb !== 0 || rd !== 32'h1234ABEF) begin n_bad++; $display("FAIL backpressure_hold: got %0d bad cycles rd=%h want 0 1234abef", hb, rd); end
        @(negedge clk);
        n_cmp++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin n_bad++; $display("FAIL backpressure_idle: got ready=%b valid=%b want 1 0", req_ready, rsp_valid); end
    endtask

    task automatic test_reset_mid_write;
        int vbad;
        vbad = 0;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = 32'h21; req_wdata = 32'h5A;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if (mem_re !== 1'b1) begin n_bad++; $display("FAIL rst_mid_rd: got re=%b want 1", mem_re); end
        @(negedge clk);
        n_cmp++; if (mem_we !== 1'b1) begin n_bad++; $display("FAIL rst_mid_wr_before: got we=%b want 1", mem_we); end
        rst_ni = 1'b0;
        #1;
        n_cmp++; if (mem_we !== 1'b0) begin n_bad++; $display("FAIL rst_mid_we_gated: got we=%b want 0", mem_we); end
        @(negedge clk);
        n_cmp++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin n_bad++; $display("FAIL rst_mid_idle: got ready=%b valid=%b want 1 0", req_ready, rsp_valid); end
        rst_ni = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0) vbad++;
        end
        n_cmp++; if (vbad !== 0) begin n_bad++; $display("FAIL rst_mid_no_rsp: got %0d valid cycles want 0", vbad); end
        n_cmp++; if (mem[8] !== ref_mem[8]) begin n_bad++; $display("FAIL rst_mid_mem: got %h want %h", mem[8], ref_mem[8]); end
    endtask

    task automatic test_bounds;
        logic [31:0] rd, wdat; logic er, rb; int lat, rc, wc, ry, wy, hb; logic [AW-1:0] ra, wa;
        logic e;
        e = ref_err(32'h4000, 2'd2);
        xact(1'b0, 2'd2, 1'b0, 32'h4000, 32'h0, 0, rd, er, lat, rc, wc, ry, wy, ra, wa, wdat, hb, rb);
        n_cmp++; if (er !== e || lat !== (e ? 1 : 2)) begin n_bad++; $display("FAIL bounds_rsp: got err=%b lat=%0d want %b", er, lat, e); end
        n_cmp++; if (rc !== (e ? 0 : 1) || ra !== '0 || rd !== (e ? 32'h0 : ref_mem[0])) begin
            n_bad++; $display("FAIL bounds_access: got re=%0d ra=%0d rd=%h want re=%0d ra=0", rc, ra, rd, e ? 0 : 1); end
    endtask

    task automatic test_random;
        logic [31:0] rd, wdat, a, wd, exp_rd, exp_w; logic er, rb, we, uns, e;
        logic [1:0] sz; int lat, rc, wc, ry, wy, hb, hold, exp_lat, diff;
        logic [AW-1:0] ra, wa, exp_a;
        for (int i = 0; i < 300; i++) begin
            we = 1'($urandom); sz = 2'($urandom); uns = 1'($urandom);
            a = ($urandom % 8 == 0) ? $urandom : $urandom_range(0, 127);
            wd = $urandom; hold = $urandom_range(0, 2);
            e = ref_err(a, sz);
            exp_a = AW'(ref_widx(a));
            exp_rd = (e || we) ? 32'h0 : ref_load(a, sz, uns);
            exp_w = ref_merge(a, sz, wd);
            exp_lat = e ? 1 : (we && sz != 2'd2) ? 3 : 2;
            xact(we, sz, uns, a, wd, hold, rd, er, lat, rc, wc, ry, wy, ra, wa, wdat, hb, rb);
            n_cmp++; if (lat !== exp_lat || er !== e) begin n_bad++; $display("FAIL rand_rsp[%0d]: got lat=%0d err=%b want %0d %b", i, lat, er, exp_lat, e); end
            n_cmp++; if (rd !== exp_rd) begin n_bad++; $display("FAIL rand_rdata[%0d]: got %h want %h (a=%h sz=%0d u=%b)", i, rd, exp_rd, a, sz, uns); end
            n_cmp++; if (rc !== ((e || (we && sz == 2'd2)) ? 0 : 1) || (rc == 1 && (ra !== exp_a || ry !== 1))) begin
                n_bad++; $display("FAIL rand_read[%0d]: got re=%0d@%0d ra=%0d want addr %0d", i, rc, ry, ra, exp_a); end
            n_cmp++; if (wc !== ((e || !we) ? 0 : 1) || (wc == 1 && (wa !== exp_a || wdat !== exp_w || wy !== exp_lat - 1))) begin
                n_bad++; $display("FAIL rand_write[%0d]: got we=%0d@%0d %h@%0d want %h@%0d", i, wc, wy, wdat, wa, exp_w, exp_a); end
            n_cmp++; if (hb !== 0 || rb !== 1'b1) begin n_bad++; $display("FAIL rand_handshake[%0d]: got hold_bad=%0d ready=%b want 0 1", i, hb, rb); end
            if (!e && we) ref_mem[ref_widx(a)] = exp_w;
        end
        @(negedge clk);
        diff = 0;
        for (int w = 0; w < NUMWORDS; w++) if (mem[w] !== ref_mem[w]) diff++;
        n_cmp++; if (diff !== 0) begin n_bad++; $display("FAIL rand_mem_image: got %0d differing words want 0", diff); end
    endtask

    initial begin
        rst_ni = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_backpressure();
        test_reset_mid_write();
        test_bounds();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
